// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_ctrl
//  Purpose  : Owns the program counter and sequences instruction fetch around
//             the next-PC unit. Runs a req/ack handshake to instruction
//             memory, holds the fetched word for decode until it is consumed,
//             then loads the next PC. Redirects to the exception vector on
//             exc_req, fetch timeout or a misaligned next PC, and counts
//             retired instructions.
//  Ports    : clk          - system clock, rising edge
//             reset_n      - asynchronous active-low reset
//             npc          - next PC from the NPC unit (function of pc)
//             pc           - current PC register
//             imem_req     - fetch request (high only while fetching)
//             imem_addr    - fetch address, equal to pc
//             imem_ack     - memory returns imem_rdata this cycle
//             imem_rdata   - fetched instruction word
//             instr        - held instruction for decode
//             instr_valid  - instr is valid and stable
//             instr_ready  - decode consumes instr this cycle
//             exc_req      - exception redirect request (level)
//             fetch_err    - one-cycle pulse on timeout or misaligned npc
//             retire_cnt   - consumed instruction count, wraps
//  Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        exc_req,
    output logic        fetch_err,
    output logic [31:0] retire_cnt
);

    // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int                 c_CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_instr;
    logic               r_instr_valid;
    logic               r_imem_req;
    logic               r_fetch_err;
    logic [31:0]        r_retire_cnt;
    logic [c_CNT_W-1:0] r_wait_cnt;

    // imem_req / instr_valid are registered alongside the state so they
    // always track it exactly: req only in FETCH, valid only in HOLD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_retire_cnt  <= 32'd0;
            r_wait_cnt    <= '0;
        end else begin
            r_fetch_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Single idle cycle; an exception here only retargets pc.
                    if (exc_req) begin
                        r_pc <= EXC_PC;
                    end
                    r_wait_cnt <= '0;
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (exc_req) begin
                        // Exception wins; a same-cycle ack is dropped.
                        r_pc       <= EXC_PC;
                        r_wait_cnt <= '0;
                        r_state    <= S_IDLE;
                        r_imem_req <= 1'b0;
                    end else if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_wait_cnt    <= '0;
                        r_state       <= S_HOLD;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_fetch_err <= 1'b1;
                        r_pc        <= EXC_PC;
                        r_wait_cnt  <= '0;
                        r_state     <= S_IDLE;
                        r_imem_req  <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (exc_req) begin
                        // No retirement even if decode consumes this cycle.
                        r_pc          <= EXC_PC;
                        r_instr_valid <= 1'b0;
                        r_wait_cnt    <= '0;
                        r_state       <= S_IDLE;
                    end else if (instr_ready) begin
                        r_retire_cnt  <= r_retire_cnt + 32'd1;
                        r_instr_valid <= 1'b0;
                        r_state       <= S_FETCH;
                        r_imem_req    <= 1'b1;
                        r_wait_cnt    <= '0;
                        // A misaligned next PC still retires the current
                        // instruction but redirects to the exception vector.
                        if (npc[1:0] == 2'b00) begin
                            r_pc <= npc;
                        end else begin
                            r_pc        <= EXC_PC;
                            r_fetch_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_instr_valid <= 1'b0;
                    r_imem_req    <= 1'b0;
                    r_wait_cnt    <= '0;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign imem_addr   = r_pc;
    assign imem_req    = r_imem_req;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign fetch_err   = r_fetch_err;
    assign retire_cnt  = r_retire_cnt;

endmodule
`default_nettype wire
